// File: rtl/uart_rx_parse.sv
// uart_rx_parse: 8N1 serial receiver feeding a parser for the fixed
// 8-character voltage frame "<sign><d>.<dddd>V", emitting sign + 5-digit BCD.
module uart_rx_parse #(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic [19:0] dec,
  output logic [7:0]  sign,
  output logic        frame_valid,
  output logic        frame_err
);

  // Bit timing in clock cycles; the counter only ever needs to reach BIT-1.
  localparam int unsigned BIT   = (CLK_FRE * 1000000) / BAUD_RATE;
  localparam int unsigned HALF  = BIT / 2;
  localparam int unsigned CNT_W = (BIT > 2) ? $clog2(BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  // Receiver states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Frame characters
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_V     = 8'h56;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  // ---------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;
  logic w_rx_fall;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_byte_done;
  logic             w_stop_err;
  logic [7:0]       r_rx_data;
  logic             r_rx_data_valid;

  // Receiver next-state: counter, bit index and shift register updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_done   = 1'b0;
    w_stop_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_fall) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = 3'd0;
          // A line that is high again mid start bit was only a glitch.
          w_state_nxt   = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          // Back to IDLE mid stop bit so a back-to-back start edge is caught.
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (r_rx_sync) begin
            w_byte_done = 1'b1;
          end else begin
            w_stop_err  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Receiver state register and registered byte output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_bit_idx       <= 3'd0;
      r_shift         <= 8'h00;
      r_rx_data       <= 8'h00;
      r_rx_data_valid <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_bit_idx       <= w_bit_idx_nxt;
      r_shift         <= w_shift_nxt;
      r_rx_data_valid <= w_byte_done;
      if (w_byte_done) begin
        r_rx_data <= r_shift;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  r_sign_sh;
  logic [7:0]  w_sign_sh_nxt;
  logic [19:0] r_dec_sh;
  logic [19:0] w_dec_sh_nxt;
  logic        w_is_sign;
  logic        w_is_digit;
  logic [3:0]  w_digit;
  logic        w_match;
  logic        w_frame_ok;
  logic        w_fmt_err;
  logic [19:0] r_dec;
  logic [7:0]  r_sign;
  logic        r_frame_valid;
  logic        r_frame_err;

  // Byte classification for the parser.
  always_comb begin
    w_is_sign  = (r_rx_data == CH_PLUS) || (r_rx_data == CH_MINUS);
    w_is_digit = (r_rx_data >= CH_ZERO) && (r_rx_data <= CH_NINE);
    w_digit    = 4'(r_rx_data - CH_ZERO);
  end

  // Parser next-state: index, shadow registers, frame_ok / format error.
  always_comb begin
    w_idx_nxt     = r_idx;
    w_sign_sh_nxt = r_sign_sh;
    w_dec_sh_nxt  = r_dec_sh;
    w_match       = 1'b0;
    w_frame_ok    = 1'b0;
    w_fmt_err     = 1'b0;
    if (w_stop_err) begin
      // A corrupted byte makes the current frame unusable.
      w_idx_nxt = 3'd0;
    end else if (r_rx_data_valid) begin
      case (r_idx)
        3'd0: begin
          // Resync silently on anything that is not a sign.
          w_match = 1'b1;
          if (w_is_sign) begin
            w_sign_sh_nxt = r_rx_data;
            w_idx_nxt     = 3'd1;
          end
        end
        3'd1: begin
          w_match = w_is_digit;
          if (w_is_digit) w_dec_sh_nxt[19:16] = w_digit;
        end
        3'd2: begin
          w_match = (r_rx_data == CH_DOT);
        end
        3'd3: begin
          w_match = w_is_digit;
          if (w_is_digit) w_dec_sh_nxt[15:12] = w_digit;
        end
        3'd4: begin
          w_match = w_is_digit;
          if (w_is_digit) w_dec_sh_nxt[11:8] = w_digit;
        end
        3'd5: begin
          w_match = w_is_digit;
          if (w_is_digit) w_dec_sh_nxt[7:4] = w_digit;
        end
        3'd6: begin
          w_match = w_is_digit;
          if (w_is_digit) w_dec_sh_nxt[3:0] = w_digit;
        end
        default: begin
          w_match    = (r_rx_data == CH_V);
          w_frame_ok = (r_rx_data == CH_V);
        end
      endcase

      if (r_idx != 3'd0) begin
        if (w_match) begin
          w_idx_nxt = (r_idx == 3'd7) ? 3'd0 : r_idx + 3'd1;
        end else begin
          // An unexpected sign is treated as the start of a new frame.
          w_fmt_err = 1'b1;
          if (w_is_sign) begin
            w_sign_sh_nxt = r_rx_data;
            w_idx_nxt     = 3'd1;
          end else begin
            w_idx_nxt     = 3'd0;
          end
        end
      end
    end
  end

  // Parser registers; visible dec/sign change only on a complete frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= 3'd0;
      r_sign_sh     <= CH_PLUS;
      r_dec_sh      <= 20'h0;
      r_dec         <= 20'h0;
      r_sign        <= CH_PLUS;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_idx         <= w_idx_nxt;
      r_sign_sh     <= w_sign_sh_nxt;
      r_dec_sh      <= w_dec_sh_nxt;
      r_frame_valid <= w_frame_ok;
      r_frame_err   <= w_stop_err | w_fmt_err;
      if (w_frame_ok) begin
        r_dec  <= r_dec_sh;
        r_sign <= r_sign_sh;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_data_valid = r_rx_data_valid;
  assign dec           = r_dec;
  assign sign          = r_sign;
  assign frame_valid   = r_frame_valid;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_uart_rx_parse.sv
// Self-checking bench for uart_rx_parse: serialises ASCII frames onto rx and
// scores bytes, frames and error pulses against expectation queues.
module tb_uart_rx_parse;

  // Faster baud than the default keeps the run short: BIT = 32, HALF = 16.
  localparam int unsigned CLK_FRE   = 50;
  localparam int unsigned BAUD_RATE = 1562500;
  localparam int unsigned BIT       = (CLK_FRE * 1000000) / BAUD_RATE;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx    = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [19:0] dec;
  logic [7:0]  sign;
  logic        frame_valid;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;

  // Expected bytes, expected frames {dec, sign}, expected errors {framing, byte}.
  logic [7:0]  q_bytes[$];
  logic [27:0] q_frames[$];
  logic [8:0]  q_errs[$];

  logic        prev_valid = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  uart_rx_parse #(
    .CLK_FRE   (CLK_FRE),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .dec           (dec),
    .sign          (sign),
    .frame_valid   (frame_valid),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  // Sends every character with a good stop bit, expecting each one back.
  task automatic send_str(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      q_bytes.push_back(c);
      send_byte(c, 1'b1);
    end
  endtask

  // Output monitor: pops the scoreboard on every output pulse.
  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [27:0] ef;
    logic [8:0]  ee;
    if (rst_n) begin
      if (rx_data_valid) begin
        check("byte_expected", 32'(q_bytes.size() != 0), 32'd1);
        if (q_bytes.size() != 0) begin
          eb = q_bytes.pop_front();
          check("rx_data", 32'(rx_data), 32'(eb));
        end
      end
      if (frame_valid) begin
        check("frame_expected", 32'(q_frames.size() != 0), 32'd1);
        check("fv_fe_exclusive", 32'(frame_err), 32'd0);
        check("fv_after_V", 32'({prev_valid, prev_data}), 32'({1'b1, 8'h56}));
        if (q_frames.size() != 0) begin
          ef = q_frames.pop_front();
          check("dec", 32'(dec), 32'(ef[27:8]));
          check("sign", 32'(sign), 32'(ef[7:0]));
        end
      end
      if (frame_err) begin
        check("err_expected", 32'(q_errs.size() != 0), 32'd1);
        if (q_errs.size() != 0) begin
          ee = q_errs.pop_front();
          if (ee[8]) begin
            check("ferr_no_byte", 32'(prev_valid), 32'd0);
          end else begin
            check("fmt_err_after_byte", 32'({prev_valid, prev_data}), 32'({1'b1, ee[7:0]}));
          end
        end
      end
    end
    prev_valid = rx_data_valid;
    prev_data  = rx_data;
  end

  task automatic check_drained(input string tag);
    check({tag, "_bytes_left"},  32'(q_bytes.size()),  32'd0);
    check({tag, "_frames_left"}, 32'(q_frames.size()), 32'd0);
    check({tag, "_errs_left"},   32'(q_errs.size()),   32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},  32'(rx_data),       32'h00);
    check({tag, "_rx_valid"}, 32'(rx_data_valid), 32'd0);
    check({tag, "_dec"},      32'(dec),           32'h0);
    check({tag, "_sign"},     32'(sign),          32'h2B);
    check({tag, "_fvalid"},   32'(frame_valid),   32'd0);
    check({tag, "_ferr"},     32'(frame_err),     32'd0);
  endtask

  initial begin
    // Reset values
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    send_idle(2 * BIT);

    // Basic frame
    q_frames.push_back({20'h12345, 8'h2B});
    send_str("+1.2345V");
    send_idle(2 * BIT);
    check_drained("basic");

    // Two frames back-to-back
    q_frames.push_back({20'h00098, 8'h2D});
    q_frames.push_back({20'h99999, 8'h2B});
    send_str("-0.0098V");
    send_str("+9.9999V");
    send_idle(2 * BIT);
    check_drained("b2b");

    // Bad digit: error on 'X', outputs hold, remainder ignored
    send_str("+1.2");
    q_errs.push_back({1'b0, 8'h58});
    send_str("X45V");
    send_idle(2 * BIT);
    check("hold_dec", 32'(dec), 32'h99999);
    check("hold_sign", 32'(sign), 32'h2B);
    q_frames.push_back({20'h33000, 8'h2B});
    send_str("ab+3.3000V");
    send_idle(2 * BIT);
    check_drained("fmt");

    // Truncated frame, resync on the next sign
    send_str("+1.2");
    q_errs.push_back({1'b0, 8'h2D});
    q_frames.push_back({20'h25000, 8'h2D});
    send_str("-2.5000V");
    send_idle(2 * BIT);
    check_drained("resync");

    // Framing error on the second byte
    send_str("+");
    q_errs.push_back({1'b1, 8'h00});
    send_byte(8'h31, 1'b0);
    send_idle(2 * BIT);
    send_str(".0000V");
    send_idle(2 * BIT);
    q_frames.push_back({20'h10000, 8'h2B});
    send_str("+1.0000V");
    send_idle(2 * BIT);
    check_drained("framing");

    // Short low glitch, shorter than half a bit
    rx = 1'b0;
    repeat (BIT / 2 - 6) @(negedge clk);
    send_idle(12 * BIT);
    check_drained("glitch");

    // Reset in the middle of the fourth byte
    send_str("+0.");
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT + BIT / 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    rx = 1'b1;
    check_drained("midrst");
    rst_n = 1'b1;
    send_idle(2 * BIT);
    q_frames.push_back({20'h05000, 8'h2B});
    send_str("+0.5000V");
    send_idle(4 * BIT);
    check_drained("final");
    check("final_dec", 32'(dec), 32'h05000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_parse.md
# uart_rx_parse

Receive-side counterpart of the voltage-report UART link. The block deserialises an 8N1 serial line and parses the fixed 8-character ASCII frame `<sign><d>.<dddd>V` (for example "+1.2345V") back into an ASCII sign byte and a 5-digit BCD value. It sits between the board RX pin and the control/loop-back logic, and its output format is the same sign/dec pair that the transmit side consumes.

## Interface
- CLK_FRE, 50, system clock frequency in MHz
- BAUD_RATE, 115200, serial bit rate; bit period BIT = CLK_FRE*1000000/BAUD_RATE cycles (integer truncation, 434 at defaults), HALF = BIT/2
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  last received byte; reset 8'h00
- rx_data_valid  output  1  one-cycle pulse when rx_data updates; reset 0
- dec  output  20  BCD value; [19:16] is the integer digit, [15:0] are the 4 fraction digits with [15:12] first; reset 20'h0
- sign  output  8  ASCII sign, 8'h2B ('+') or 8'h2D ('-'); reset 8'h2B
- frame_valid  output  1  one-cycle pulse when dec/sign update; reset 0
- frame_err  output  1  one-cycle pulse on framing or format error; reset 0

## Operation
- rx passes through a 2-flop synchroniser, reset to 1. All logic uses only the synchronised value.
- Receiver FSM states are IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of the synchronised rx, go to START and clear the bit counter.
  - START: after HALF cycles, sample rx. If it is 0, go to DATA. If it is 1, this is a glitch: return to IDLE with no output.
  - DATA: sample rx every BIT cycles. Data is LSB first; 8 samples are taken.
  - STOP: BIT cycles after the last data sample, sample the stop bit.
    - Stop bit 1: load rx_data and pulse rx_data_valid.
    - Stop bit 0: pulse frame_err, do not update rx_data, and reset the parser index to 0.
    - In both cases return to IDLE immediately, so the next start edge can be seen during the second half of the stop bit.
- Parser uses an index idx in 0..7 and advances only on rx_data_valid.
  - idx0: accept 8'h2B or 8'h2D, latch it into the sign shadow register, and go to idx 1. Any other byte is ignored silently (resync), with no frame_err.
  - idx1 and idx3..6: expect a digit 8'h30..8'h39. Store byte-48 into the BCD shadow nibble: idx1 goes to [19:16], idx3..6 go to [15:12]..[3:0].
  - idx2: expect 8'h2E ('.').
  - idx7: expect 8'h56 ('V'). On a match, copy the shadow registers to dec/sign, pulse frame_valid, and set idx to 0.
  - Mismatch at idx1..7: pulse frame_err. If the offending byte is '+' or '-', it is latched as the new sign and idx goes to 1. Otherwise idx goes to 0.
- dec/sign change only on frame_valid. They hold their last good frame through errors.
- Shadow registers are not visible on outputs.

## Timing
- Synchroniser latency is 2 cycles from an rx pin edge.
- The start sample is taken HALF cycles after the detected edge. Data sample k (k=0..7) is taken HALF+(k+1)*BIT cycles after the edge. The stop sample is taken HALF+9*BIT cycles after the edge.
- rx_data/rx_data_valid are registered 1 cycle after the stop sample. frame_err for a framing error is also 1 cycle after the stop sample.
- frame_valid and the dec/sign update occur 1 cycle after the rx_data_valid of the 'V' byte. A format frame_err also occurs 1 cycle after the offending rx_data_valid.
- frame_valid and frame_err never assert in the same cycle.
- Back-to-back bytes with no idle gap between the stop bit and the next start bit are received without loss.
- Reset asserted mid-byte or mid-frame:
  - all outputs return to their reset values immediately;
  - FSM goes to IDLE and idx to 0;
  - after release, the partial frame is discarded and the next valid frame is decoded normally.
- The bit counter is wide enough for BIT-1. No drift correction is applied; sampling is re-anchored only at each start edge.

## Test plan
- Defaults, bytes sent at exact BIT=434: "+1.2345V" -> eight rx_data_valid pulses; then exactly one frame_valid with dec=20'h12345 and sign=8'h2B; frame_err never asserts.
- "-0.0098V" followed back-to-back by "+9.9999V" -> first frame_valid gives dec=20'h00098, sign=8'h2D; second gives dec=20'h99999, sign=8'h2B.
- "+1.2X45V" -> frame_err pulse one cycle after the 'X' byte; no frame_valid; dec/sign keep their previous values. Then "ab+3.3000V" -> 'a' and 'b' are ignored with no frame_err, and the frame yields dec=20'h33000.
- "+1.2" followed by "-2.5000V" -> frame_err on the '-' byte, then frame_valid with dec=20'h25000 and sign=8'h2D (resync on sign).
- Framing error: the second byte of "+1.0000V" is sent with stop bit 0 -> frame_err pulse, no rx_data_valid for that byte, no frame_valid. Then a clean "+1.0000V" -> dec=20'h10000.
- A 100-cycle low glitch on rx produces no rx_data_valid. Reset pulsed during the 4th byte of a frame: all outputs are at their reset values; a following "+0.5000V" yields dec=20'h05000.
